// File: rtl/regfile_wb_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// regfile_wb_arbiter_pkg
//   Shared constants and types for the register-file writeback arbiter.
//   - WB_* source indices and counts for the default 3-source configuration
//     (pipeline WB, LSU/AXI load return, mul/div unit).
//   - REG_ADDR_W / REG_DATA_W: register-file address and data bus widths.
//   - gnt_kind_e: the reason a source was granted in a given cycle.
// -----------------------------------------------------------------------------
package regfile_wb_arbiter_pkg;

    localparam int REG_ADDR_W      = 5;
    localparam int REG_DATA_W      = 32;

    localparam int WB_NUM_REQ      = 3;
    localparam int WB_SRC_PIPE     = 0;
    localparam int WB_SRC_LSU      = 1;
    localparam int WB_SRC_MDU      = 2;
    localparam int WB_STARVE_LIMIT = 4;

    // Counter width covers the largest legal STARVE_LIMIT (15).
    localparam int STARVE_CNT_W    = 4;

    typedef enum logic [1:0] {
        GNT_NONE     = 2'd0,
        GNT_OVERRIDE = 2'd1,
        GNT_HIPRI    = 2'd2,
        GNT_RR       = 2'd3
    } gnt_kind_e;

endpackage

// File: rtl/regfile_wb_arbiter_rr_pick.sv
// -----------------------------------------------------------------------------
// regfile_wb_arbiter_rr_pick
//   Combinational round-robin one-hot picker. Searches req & mask upward
//   from ptr, wrapping past NUM_REQ-1 to 0, and returns the first hit.
//   Ports:
//     req        in   NUM_REQ  request vector
//     mask       in   NUM_REQ  eligible sources (1 = may be picked)
//     ptr        in   PTR_W    index where the search starts (< NUM_REQ)
//     grant      out  NUM_REQ  one-hot pick, zero when nothing eligible
//     grant_idx  out  PTR_W    binary index of the pick
//     any        out  1        a pick was made
// -----------------------------------------------------------------------------
module regfile_wb_arbiter_rr_pick #(
    parameter int NUM_REQ = 3,
    parameter int PTR_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [NUM_REQ-1:0] mask,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [PTR_W-1:0]   grant_idx,
    output logic               any
);

    always_comb begin
        int idx;
        // NOTE: every output gets a default before the search loop so no
        // path leaves a value unassigned, which would infer a latch.
        grant     = '0;
        grant_idx = '0;
        any       = 1'b0;
        idx       = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(ptr) + k) % NUM_REQ;
            if (!any && req[idx] && mask[idx]) begin
                any        = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = PTR_W'(idx);
            end
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// -----------------------------------------------------------------------------
// regfile_wb_arbiter
//   Shares the single register-file write port among NUM_REQ writeback
//   sources. Grant is combinational in the request cycle; the chosen write
//   reaches the register file through a one-cycle output register.
//   Grant priority: starvation override > HIPRI > round-robin of the rest.
//   Ports:
//     clk          in   1               system clock
//     rst_n        in   1               async active-low reset
//     req_valid    in   NUM_REQ         per-source write request
//     req_addr     in   NUM_REQ*ADDR_W  source i at [i*ADDR_W +: ADDR_W]
//     req_data     in   NUM_REQ*DATA_W  source i at [i*DATA_W +: DATA_W]
//     req_ready    out  NUM_REQ         one-hot grant (handshake = valid&ready)
//     hipri_stall  out  1               HIPRI valid but not granted
//     write_en     out  1               register-file write enable (registered)
//     write_addr   out  ADDR_W          register-file write address (registered)
//     write_data   out  DATA_W          register-file write data (registered)
// -----------------------------------------------------------------------------
module regfile_wb_arbiter
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int NUM_REQ      = WB_NUM_REQ,
    parameter int HIPRI        = WB_SRC_PIPE,
    parameter int STARVE_LIMIT = WB_STARVE_LIMIT,
    parameter int ADDR_W       = REG_ADDR_W,
    parameter int DATA_W       = REG_DATA_W
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      hipri_stall,
    output logic                      write_en,
    output logic [ADDR_W-1:0]         write_addr,
    output logic [DATA_W-1:0]         write_data
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [NUM_REQ-1:0] LO_MASK = ~(NUM_REQ'(1) << HIPRI);
    localparam logic [STARVE_CNT_W-1:0] CNT_MAX = STARVE_CNT_W'(STARVE_LIMIT);

    logic [PTR_W-1:0]        rr_ptr;
    logic [STARVE_CNT_W-1:0] starve_cnt [NUM_REQ];

    logic [NUM_REQ-1:0]      rr_grant;
    logic [PTR_W-1:0]        rr_idx;
    logic                    rr_any;

    logic [NUM_REQ-1:0]      grant;
    logic [PTR_W-1:0]        gnt_idx;
    gnt_kind_e               gnt_kind;
    logic [ADDR_W-1:0]       sel_addr;
    logic [DATA_W-1:0]       sel_data;

    regfile_wb_arbiter_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_rr_pick (
        .req       (req_valid),
        .mask      (LO_MASK),
        .ptr       (rr_ptr),
        .grant     (rr_grant),
        .grant_idx (rr_idx),
        .any       (rr_any)
    );

    // Priority mux. A counter only reaches the limit while its source is
    // still valid, but valid is re-checked so a grant never goes to an idle
    // source.
    always_comb begin
        grant    = '0;
        gnt_idx  = '0;
        gnt_kind = GNT_NONE;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (i != HIPRI && gnt_kind == GNT_NONE &&
                req_valid[i] && starve_cnt[i] == CNT_MAX) begin
                grant[i] = 1'b1;
                gnt_idx  = PTR_W'(i);
                gnt_kind = GNT_OVERRIDE;
            end
        end
        if (gnt_kind == GNT_NONE) begin
            if (req_valid[HIPRI]) begin
                grant[HIPRI] = 1'b1;
                gnt_idx      = PTR_W'(HIPRI);
                gnt_kind     = GNT_HIPRI;
            end else if (rr_any) begin
                grant    = rr_grant;
                gnt_idx  = rr_idx;
                gnt_kind = GNT_RR;
            end
        end
    end

    // Grants are suppressed while reset is held so no source sees a
    // handshake that the cleared output register would then lose.
    assign req_ready   = rst_n ? grant : '0;
    assign hipri_stall = rst_n & req_valid[HIPRI] & ~grant[HIPRI];

    assign sel_addr = req_addr[int'(gnt_idx)*ADDR_W +: ADDR_W];
    assign sel_data = req_data[int'(gnt_idx)*DATA_W +: DATA_W];

    // Round-robin pointer: only a round-robin win moves it, so HIPRI and
    // starvation-override wins do not disturb fairness among the others.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= '0;
        end else if (gnt_kind == GNT_RR) begin
            // NOTE: sequential state is updated with non-blocking assignments
            // so every register samples pre-edge values.
            rr_ptr <= (int'(gnt_idx) == NUM_REQ - 1) ? '0 : gnt_idx + PTR_W'(1);
        end
    end

    // Starvation counters: count cycles a waiting low-priority source loses
    // to HIPRI, saturating at the limit. The HIPRI slot stays at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: this small counter array is plain flops, not a RAM, so it
            // is cleared element by element in the reset branch.
            for (int i = 0; i < NUM_REQ; i++) begin
                starve_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (i == HIPRI || !req_valid[i] || grant[i]) begin
                    starve_cnt[i] <= '0;
                end else if (grant[HIPRI] && starve_cnt[i] < CNT_MAX) begin
                    starve_cnt[i] <= starve_cnt[i] + STARVE_CNT_W'(1);
                end
            end
        end
    end

    // Write stage. Writes to r0 are consumed but never enabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            write_en   <= 1'b0;
            write_addr <= '0;
            write_data <= '0;
        end else if (gnt_kind != GNT_NONE) begin
            write_en   <= (sel_addr != '0);
            write_addr <= sel_addr;
            write_data <= sel_data;
        end else begin
            write_en   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_regfile_wb_arbiter
//   Directed testbench for regfile_wb_arbiter in its default configuration
//   (3 sources, HIPRI=0, STARVE_LIMIT=4). Inputs change on the falling edge;
//   the combinational grant is sampled 1 ns later and the registered write
//   outputs on the following falling edge.
// -----------------------------------------------------------------------------
module tb_regfile_wb_arbiter;

    localparam int NUM_REQ = 3;
    localparam int ADDR_W  = 5;
    localparam int DATA_W  = 32;

    logic                      clk;
    logic                      rst_n;
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        req_ready;
    logic                      hipri_stall;
    logic                      write_en;
    logic [ADDR_W-1:0]         write_addr;
    logic [DATA_W-1:0]         write_data;

    int tests_run;
    int tests_failed;

    regfile_wb_arbiter dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_addr    (req_addr),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .hipri_stall (hipri_stall),
        .write_en    (write_en),
        .write_addr  (write_addr),
        .write_data  (write_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic set_src(input int i, input logic v,
                           input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        req_valid[i]              = v;
        req_addr[i*ADDR_W +: ADDR_W] = a;
        req_data[i*DATA_W +: DATA_W] = d;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n     = 1'b0;
        req_valid = '0;
        req_addr  = '0;
        req_data  = '0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        apply_reset();
        #1;
        tests_run++;
        if (req_ready !== 3'b000) begin
            tests_failed++;
            $display("FAIL reset_ready: got %b expected 000", req_ready);
        end
        tests_run++;
        if ({write_en, write_addr, write_data} !== '0) begin
            tests_failed++;
            $display("FAIL reset_write: got en=%b addr=%0d data=%h expected 0/0/0",
                     write_en, write_addr, write_data);
        end
        // Move rr_ptr away from 0 with a round-robin grant to source 1.
        @(negedge clk);
        set_src(1, 1'b1, 5'd3, 32'h1111_0001);
        @(negedge clk);
        set_src(0, 1'b1, 5'd1, 32'h0);
        set_src(1, 1'b1, 5'd2, 32'h0);
        set_src(2, 1'b1, 5'd4, 32'h0);
        #1;
        tests_run++;
        if (req_ready !== 3'b001) begin
            tests_failed++;
            $display("FAIL burst_ready: got %b expected 001", req_ready);
        end
        // Reset asserted mid-burst, away from any clock edge.
        #2 rst_n = 1'b0;
        #1;
        tests_run++;
        if (req_ready !== 3'b000 || hipri_stall !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_midburst_ready: got ready=%b stall=%b expected 000/0",
                     req_ready, hipri_stall);
        end
        tests_run++;
        if (write_en !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_midburst_write_en: got %b expected 0", write_en);
        end
        @(negedge clk);
        rst_n = 1'b1;
        set_src(0, 1'b0, 5'd0, 32'h0);
        #1;
        // rr_ptr back at 0: source 1 wins over source 2.
        tests_run++;
        if (req_ready !== 3'b010) begin
            tests_failed++;
            $display("FAIL reset_rr_ptr: got %b expected 010", req_ready);
        end
        @(negedge clk);
        req_valid = '0;
    endtask

    task automatic test_single();
        apply_reset();
        set_src(1, 1'b1, 5'd5, 32'hDEAD_BEEF);
        #1;
        tests_run++;
        if (req_ready !== 3'b010 || hipri_stall !== 1'b0) begin
            tests_failed++;
            $display("FAIL single_ready: got ready=%b stall=%b expected 010/0",
                     req_ready, hipri_stall);
        end
        @(negedge clk);
        req_valid = '0;
        tests_run++;
        if (write_en !== 1'b1 || write_addr !== 5'd5 || write_data !== 32'hDEAD_BEEF) begin
            tests_failed++;
            $display("FAIL single_write: got en=%b addr=%0d data=%h expected 1/5/deadbeef",
                     write_en, write_addr, write_data);
        end
        @(negedge clk);
        tests_run++;
        if (write_en !== 1'b0 || write_addr !== 5'd5 || write_data !== 32'hDEAD_BEEF) begin
            tests_failed++;
            $display("FAIL single_idle_hold: got en=%b addr=%0d data=%h expected 0/5/deadbeef",
                     write_en, write_addr, write_data);
        end
    endtask

    task automatic test_round_robin();
        logic [NUM_REQ-1:0] exp_gnt [4];
        logic [ADDR_W-1:0]  exp_a   [4];
        exp_gnt = '{3'b010, 3'b100, 3'b010, 3'b100};
        exp_a   = '{5'd7, 5'd9, 5'd7, 5'd9};
        apply_reset();
        set_src(1, 1'b1, 5'd7, 32'hAAAA_0001);
        set_src(2, 1'b1, 5'd9, 32'hAAAA_0002);
        for (int k = 0; k < 4; k++) begin
            #1;
            tests_run++;
            if (req_ready !== exp_gnt[k]) begin
                tests_failed++;
                $display("FAIL rr_grant[%0d]: got %b expected %b", k, req_ready, exp_gnt[k]);
            end
            @(negedge clk);
            if (k == 3) req_valid = '0;
            tests_run++;
            if (write_en !== 1'b1 || write_addr !== exp_a[k]) begin
                tests_failed++;
                $display("FAIL rr_write[%0d]: got en=%b addr=%0d expected 1/%0d",
                         k, write_en, write_addr, exp_a[k]);
            end
        end
    endtask

    task automatic test_starvation();
        apply_reset();
        set_src(0, 1'b1, 5'd3, 32'hBBBB_0000);
        set_src(1, 1'b1, 5'd4, 32'hBBBB_0001);
        for (int k = 0; k < 6; k++) begin
            logic [NUM_REQ-1:0] eg;
            logic               es;
            eg = (k == 4) ? 3'b010 : 3'b001;
            es = (k == 4);
            #1;
            tests_run++;
            if (req_ready !== eg || hipri_stall !== es) begin
                tests_failed++;
                $display("FAIL starve_cycle[%0d]: got ready=%b stall=%b expected %b/%b",
                         k, req_ready, hipri_stall, eg, es);
            end
            @(negedge clk);
            if (k == 4) set_src(1, 1'b0, 5'd0, 32'h0);
            if (k == 4) begin
                tests_run++;
                if (write_en !== 1'b1 || write_addr !== 5'd4 || write_data !== 32'hBBBB_0001) begin
                    tests_failed++;
                    $display("FAIL starve_override_write: got en=%b addr=%0d data=%h expected 1/4/bbbb0001",
                             write_en, write_addr, write_data);
                end
            end
        end
        req_valid = '0;
    endtask

    task automatic test_r0_write();
        apply_reset();
        // Source 1 first so rr_ptr sits at 2 before the r0 write.
        set_src(1, 1'b1, 5'd6, 32'hCCCC_0001);
        @(negedge clk);
        set_src(1, 1'b0, 5'd0, 32'h0);
        set_src(2, 1'b1, 5'd0, 32'hCCCC_0002);
        #1;
        tests_run++;
        if (req_ready !== 3'b100) begin
            tests_failed++;
            $display("FAIL r0_ready: got %b expected 100", req_ready);
        end
        @(negedge clk);
        tests_run++;
        if (write_en !== 1'b0 || write_addr !== 5'd0) begin
            tests_failed++;
            $display("FAIL r0_write_en: got en=%b addr=%0d expected 0/0", write_en, write_addr);
        end
        // rr_ptr wrapped to 0, so source 1 beats source 2.
        set_src(1, 1'b1, 5'd8, 32'hCCCC_0003);
        set_src(2, 1'b1, 5'd9, 32'hCCCC_0004);
        #1;
        tests_run++;
        if (req_ready !== 3'b010) begin
            tests_failed++;
            $display("FAIL r0_rr_wrap: got %b expected 010", req_ready);
        end
        @(negedge clk);
        req_valid = '0;
    endtask

    task automatic test_held_request();
        logic [ADDR_W-1:0] exp_a [4];
        logic [DATA_W-1:0] exp_d [4];
        int n_wr;
        int n_src1;
        exp_a  = '{5'd10, 5'd11, 5'd12, 5'd20};
        exp_d  = '{32'hD000_0010, 32'hD000_0011, 32'hD000_0012, 32'hD000_0020};
        n_wr   = 0;
        n_src1 = 0;
        apply_reset();
        for (int c = 0; c < 6; c++) begin
            if (c < 3) begin
                set_src(0, 1'b1, exp_a[c], exp_d[c]);
                set_src(1, 1'b1, 5'd20, 32'hD000_0020);
            end else if (c == 3) begin
                set_src(0, 1'b0, 5'd0, 32'h0);
            end else begin
                req_valid = '0;
            end
            @(negedge clk);
            if (write_en === 1'b1) begin
                tests_run++;
                if (n_wr >= 4) begin
                    tests_failed++;
                    $display("FAIL held_extra_write: got addr=%0d expected no write", write_addr);
                end else if (write_addr !== exp_a[n_wr] || write_data !== exp_d[n_wr]) begin
                    tests_failed++;
                    $display("FAIL held_write[%0d]: got %0d/%h expected %0d/%h",
                             n_wr, write_addr, write_data, exp_a[n_wr], exp_d[n_wr]);
                end
                if (write_addr === 5'd20) n_src1++;
                n_wr++;
            end
        end
        tests_run++;
        if (n_wr != 4 || n_src1 != 1) begin
            tests_failed++;
            $display("FAIL held_write_count: got total=%0d src1=%0d expected 4/1", n_wr, n_src1);
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst_n        = 1'b0;
        req_valid    = '0;
        req_addr     = '0;
        req_data     = '0;
        test_reset();
        test_single();
        test_round_robin();
        test_starvation();
        test_r0_write();
        test_held_request();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    // Hard time limit so a stuck run still ends with a report.
    initial begin
        #100000;
        $display("FAIL timeout: got no completion expected finish before 100000 ns");
        $fatal(1, "timeout");
    end

endmodule
